// File: rtl/ioread_ctrl.sv
// ----------------------------------------------------------------------------
// ioread_ctrl
//
// Serves CPU IO reads from N_CH switch channels. A request (ior) selects one
// channel with a one-hot ch_sel; the read completes only when the operator
// presses the enter button (synchronised and debounced here). The captured
// channel value is held on ioread_data and isIOReadOK stays high until the
// requester drops ior.
//
// Optional feature macro: IOREAD_TIMEOUT_EN
//   When defined, a WAIT that sees no press for TIMEOUT_CYC cycles completes
//   with ioread_data = 0 and timeout = 1. When undefined, WAIT waits forever
//   and timeout is tied low.
//
// Ports:
//   clk          in   1            CPU clock, rising edge
//   reset        in   1            synchronous active-high reset
//   ior          in   1            read request, held until isIOReadOK seen
//   ch_sel       in   N_CH         one-hot channel select (bit j = slice j)
//   sw_in        in   N_CH*DATA_W  raw switch bus, channel 0 is the MS slice
//   enter        in   1            raw asynchronous enter button
//   ioread_data  out  DATA_W       captured channel value (registered)
//   isIOReadOK   out  1            read complete
//   busy         out  1            waiting for a press
//   sel_err      out  1            ch_sel was not one-hot at request
//   timeout      out  1            read ended by timeout (feature only)
//
// State table:
//   S_IDLE | no read in progress, waiting for ior
//   S_WAIT | request accepted, waiting for a debounced press
//   S_DONE | data captured, isIOReadOK held until ior falls
//   S_ERR  | ch_sel was not one-hot, sel_err held until ior falls
// ----------------------------------------------------------------------------
module ioread_ctrl #(
    parameter int DATA_W       = 8,
    parameter int N_CH         = 2,
    parameter int DEBOUNCE_CYC = 20000,
    parameter int TIMEOUT_CYC  = 1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ior,
    input  logic [N_CH-1:0]          ch_sel,
    input  logic [N_CH*DATA_W-1:0]   sw_in,
    input  logic                     enter,
    output logic [DATA_W-1:0]        ioread_data,
    output logic                     isIOReadOK,
    output logic                     busy,
    output logic                     sel_err,
    output logic                     timeout
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // enter synchroniser
    // ------------------------------------------------------------------
    logic enter_s1, enter_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            enter_s1 <= 1'b0;
            enter_s2 <= 1'b0;
        end else begin
            enter_s1 <= enter;
            enter_s2 <= enter_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer. The level flips on the edge where the counter would reach
    // DEBOUNCE_CYC; press is registered on that same edge so it is high
    // for exactly the cycle after the flip.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt;
    logic            db_level;
    logic            press;

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (enter_s2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt   <= '0;
                db_level <= enter_s2;
                press    <= enter_s2;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel select decode and slice mux
    // ------------------------------------------------------------------
    logic              sel_onehot;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  ch_idx;
    logic [DATA_W-1:0] ch_slice;

    always_comb begin
        sel_onehot = $onehot(ch_sel);
        sel_idx    = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (ch_sel[j]) sel_idx = IDX_W'(j);
        end
    end

    // ch_sel bit j picks sw_in slice j, so the MSB of ch_sel picks channel 0.
    always_comb begin
        ch_slice = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (ch_idx == IDX_W'(j)) ch_slice = sw_in[j*DATA_W +: DATA_W];
        end
    end

    // ------------------------------------------------------------------
    // WAIT timeout
    // ------------------------------------------------------------------
    logic to_hit;

`ifdef IOREAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] wait_cnt;
    logic            to_flag;

    // Held at zero outside WAIT, so it starts from zero on every entry.
    always_ff @(posedge clk) begin
        if (reset || state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    assign to_hit = (state == S_WAIT) && (wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            to_flag <= 1'b0;
        end else if (state == S_WAIT && ior) begin
            to_flag <= !press && to_hit;
        end else if (state == S_DONE && !ior) begin
            to_flag <= 1'b0;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Abort beats press, press beats timeout.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ior) state_nxt = sel_onehot ? S_WAIT : S_ERR;
            end
            S_WAIT: begin
                if (!ior)        state_nxt = S_IDLE;
                else if (press)  state_nxt = S_DONE;
                else if (to_hit) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!ior) state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (!ior) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registers only
    // ------------------------------------------------------------------
    always_comb begin
        busy       = (state == S_WAIT);
        isIOReadOK = (state == S_DONE);
        sel_err    = (state == S_ERR);
`ifdef IOREAD_TIMEOUT_EN
        timeout    = (state == S_DONE) && to_flag;
`else
        timeout    = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Channel index latch and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_idx      <= '0;
            ioread_data <= '0;
        end else begin
            if (state == S_IDLE && ior && sel_onehot) begin
                ch_idx <= sel_idx;
            end
            if (state == S_WAIT && ior) begin
                if (press)       ioread_data <= ch_slice;
                else if (to_hit) ioread_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ioread_ctrl.sv
module tb_ioread_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ior;
    logic [1:0]  ch_sel;
    logic [15:0] sw_in;
    logic        enter;
    logic [7:0]  ioread_data;
    logic        isIOReadOK;
    logic        busy;
    logic        sel_err;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    ioread_ctrl #(
        .DATA_W      (8),
        .N_CH        (2),
        .DEBOUNCE_CYC(4),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ior        (ior),
        .ch_sel     (ch_sel),
        .sw_in      (sw_in),
        .enter      (enter),
        .ioread_data(ioread_data),
        .isIOReadOK (isIOReadOK),
        .busy       (busy),
        .sel_err    (sel_err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; ior = 1'b0; ch_sel = 2'b00; sw_in = 16'h0000; enter = 1'b0;
        step(2);
        checks++;
        if ({ioread_data, isIOReadOK, busy, sel_err, timeout} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got data=%h ok=%b busy=%b err=%b to=%b want all 0",
                     ioread_data, isIOReadOK, busy, sel_err, timeout);
        end
        reset = 1'b0;
        step(1);
    endtask

    // Full read: press latency is DEBOUNCE_CYC+3 falling edges from enter
    // rising to isIOReadOK visible (2 sync + 4 debounce + 1 FSM).
    task automatic do_read(input logic [1:0] sel, input logic [15:0] sw,
                           input logic [7:0] exp, input string name);
        sw_in = sw; ch_sel = sel; ior = 1'b1;
        step(1);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy got %b want 1", name, busy);
        end
        enter = 1'b1;
        step(6);
        checks++;
        if (busy !== 1'b1 || isIOReadOK !== 1'b0) begin
            errors++; $display("FAIL %s pre_press busy=%b ok=%b want 1 0", name, busy, isIOReadOK);
        end
        step(1);
        checks++;
        if (isIOReadOK !== 1'b1 || ioread_data !== exp || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s done ok=%b data=%h busy=%b to=%b want 1 %h 0 0",
                     name, isIOReadOK, ioread_data, busy, timeout, exp);
        end
        step(3);
        enter = 1'b0;
        sw_in = ~sw;
        step(2);
        checks++;
        if (isIOReadOK !== 1'b1 || ioread_data !== exp) begin
            errors++; $display("FAIL %s hold ok=%b data=%h want 1 %h", name, isIOReadOK, ioread_data, exp);
        end
        ior = 1'b0;
        step(1);
        checks++;
        if (isIOReadOK !== 1'b0 || ioread_data !== exp) begin
            errors++; $display("FAIL %s release ok=%b data=%h want 0 %h", name, isIOReadOK, ioread_data, exp);
        end
        step(8);
    endtask

    task automatic test_sel_err();
        sw_in = 16'h1234; ch_sel = 2'b11; ior = 1'b1;
        step(1);
        checks++;
        if (sel_err !== 1'b1 || isIOReadOK !== 1'b0 || busy !== 1'b0 || ioread_data !== 8'h5A) begin
            errors++;
            $display("FAIL sel_err_11 err=%b ok=%b busy=%b data=%h want 1 0 0 5a",
                     sel_err, isIOReadOK, busy, ioread_data);
        end
        enter = 1'b1;
        step(8);
        checks++;
        if (sel_err !== 1'b1 || isIOReadOK !== 1'b0 || ioread_data !== 8'h5A) begin
            errors++;
            $display("FAIL sel_err_press err=%b ok=%b data=%h want 1 0 5a", sel_err, isIOReadOK, ioread_data);
        end
        ior = 1'b0; enter = 1'b0;
        step(1);
        checks++;
        if (sel_err !== 1'b0) begin
            errors++; $display("FAIL sel_err_clear got %b want 0", sel_err);
        end
        step(8);
        ch_sel = 2'b00; ior = 1'b1;
        step(1);
        checks++;
        if (sel_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL sel_err_00 err=%b busy=%b want 1 0", sel_err, busy);
        end
        ior = 1'b0;
        step(2);
    endtask

    task automatic test_bounce();
        bit seen_ok = 1'b0;
        sw_in = 16'h3CFF; ch_sel = 2'b10; ior = 1'b1;
        step(1);
        for (int i = 0; i < 10; i++) begin
            enter = ~i[0];
            step(2);
            if (isIOReadOK) seen_ok = 1'b1;
        end
        checks++;
        if (seen_ok || busy !== 1'b1) begin
            errors++; $display("FAIL bounce_no_press ok_seen=%b busy=%b want 0 1", seen_ok, busy);
        end
        enter = 1'b1;
        step(6);
        checks++;
        if (isIOReadOK !== 1'b0) begin
            errors++; $display("FAIL bounce_early ok got %b want 0", isIOReadOK);
        end
        step(1);
        checks++;
        if (isIOReadOK !== 1'b1 || ioread_data !== 8'h3C) begin
            errors++; $display("FAIL bounce_capture ok=%b data=%h want 1 3c", isIOReadOK, ioread_data);
        end
        sw_in = 16'h7700;
        step(10);
        checks++;
        if (isIOReadOK !== 1'b1 || ioread_data !== 8'h3C) begin
            errors++; $display("FAIL bounce_once ok=%b data=%h want 1 3c", isIOReadOK, ioread_data);
        end
        ior = 1'b0; enter = 1'b0;
        step(8);
    endtask

    task automatic test_held_before();
        enter = 1'b1;
        step(10);
        sw_in = 16'hFFC3; ch_sel = 2'b01; ior = 1'b1;
        step(10);
        checks++;
        if (isIOReadOK !== 1'b0 || busy !== 1'b1 || ioread_data !== 8'h3C) begin
            errors++;
            $display("FAIL held_no_capture ok=%b busy=%b data=%h want 0 1 3c", isIOReadOK, busy, ioread_data);
        end
        enter = 1'b0;
        step(8);
        enter = 1'b1;
        step(7);
        checks++;
        if (isIOReadOK !== 1'b1 || ioread_data !== 8'hC3) begin
            errors++; $display("FAIL held_repress ok=%b data=%h want 1 c3", isIOReadOK, ioread_data);
        end
        ior = 1'b0; enter = 1'b0;
        step(8);
    endtask

    task automatic test_abort();
        sw_in = 16'h9911; ch_sel = 2'b10; ior = 1'b1;
        step(1);
        enter = 1'b1;
        step(3);
        ior = 1'b0;
        step(1);
        checks++;
        if (busy !== 1'b0 || isIOReadOK !== 1'b0) begin
            errors++; $display("FAIL abort_idle busy=%b ok=%b want 0 0", busy, isIOReadOK);
        end
        step(6);
        checks++;
        if (isIOReadOK !== 1'b0 || ioread_data !== 8'hC3) begin
            errors++; $display("FAIL abort_late_press ok=%b data=%h want 0 c3", isIOReadOK, ioread_data);
        end
        enter = 1'b0;
        step(8);
    endtask

    task automatic test_reset_mid_wait();
        sw_in = 16'h4455; ch_sel = 2'b01; ior = 1'b1;
        step(1);
        enter = 1'b1;
        step(2);
        reset = 1'b1; ior = 1'b0;
        step(1);
        checks++;
        if ({ioread_data, isIOReadOK, busy, sel_err, timeout} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_wait got data=%h ok=%b busy=%b err=%b to=%b want all 0",
                     ioread_data, isIOReadOK, busy, sel_err, timeout);
        end
        reset = 1'b0;
        step(10);
        checks++;
        if (isIOReadOK !== 1'b0 || busy !== 1'b0 || ioread_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_late_press ok=%b busy=%b data=%h want 0 0 00", isIOReadOK, busy, ioread_data);
        end
        enter = 1'b0;
        step(8);
    endtask

    task automatic test_back_to_back();
        sw_in = 16'h1122; ch_sel = 2'b01; ior = 1'b1;
        step(1);
        enter = 1'b1;
        step(7);
        checks++;
        if (isIOReadOK !== 1'b1 || ioread_data !== 8'h22) begin
            errors++; $display("FAIL b2b_first ok=%b data=%h want 1 22", isIOReadOK, ioread_data);
        end
        ior = 1'b0;
        step(1);
        ch_sel = 2'b10; ior = 1'b1; enter = 1'b0;
        step(1);
        checks++;
        if (busy !== 1'b1 || isIOReadOK !== 1'b0) begin
            errors++; $display("FAIL b2b_accept busy=%b ok=%b want 1 0", busy, isIOReadOK);
        end
        step(8);
        enter = 1'b1;
        step(7);
        checks++;
        if (isIOReadOK !== 1'b1 || ioread_data !== 8'h11) begin
            errors++; $display("FAIL b2b_second ok=%b data=%h want 1 11", isIOReadOK, ioread_data);
        end
        ior = 1'b0; enter = 1'b0;
        step(8);
    endtask

    task automatic test_timeout();
        sw_in = 16'hABCD; ch_sel = 2'b10; ior = 1'b1;
        step(50);
        checks++;
        if (busy !== 1'b1 || isIOReadOK !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait busy=%b ok=%b to=%b want 1 0 0", busy, isIOReadOK, timeout);
        end
`ifdef IOREAD_TIMEOUT_EN
        step(1);
        checks++;
        if (isIOReadOK !== 1'b1 || timeout !== 1'b1 || ioread_data !== 8'h00) begin
            errors++;
            $display("FAIL timeout_done ok=%b to=%b data=%h want 1 1 00", isIOReadOK, timeout, ioread_data);
        end
        ior = 1'b0;
        step(1);
        checks++;
        if (isIOReadOK !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_clear ok=%b to=%b want 0 0", isIOReadOK, timeout);
        end
`else
        step(20);
        checks++;
        if (busy !== 1'b1 || isIOReadOK !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout busy=%b ok=%b to=%b want 1 0 0", busy, isIOReadOK, timeout);
        end
        ior = 1'b0;
        step(1);
`endif
        step(2);
    endtask

    initial begin
        test_reset();
        do_read(2'b10, 16'hA55A, 8'hA5, "read_ch0");
        do_read(2'b01, 16'hA55A, 8'h5A, "read_ch1");
        test_sel_err();
        test_bounce();
        test_held_before();
        test_abort();
        test_reset_mid_wait();
        test_back_to_back();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioread_ctrl.md
Name: ioread_ctrl

Overview:
- Parametrised, handshaked successor to the switch-read path.
- Serves CPU IO reads from N_CH switch channels of DATA_W bits each; a read completes only on a debounced press of the enter button.
- Sits between the Controller/memorio read path and the board switches/button.
- Adds over the previous block: enter synchroniser and debouncer, registered FSM, one-hot channel select with error flag, held-result handshake, optional timeout.

Parameters:
- DATA_W, 8, width of one channel and of ioread_data (>=1).
- N_CH, 2, number of switch channels (>=1). Channel 0 is the most-significant slice of sw_in.
- DEBOUNCE_CYC, 20000, consecutive stable cycles needed to accept an enter level change (>=1).
- TIMEOUT_CYC, 1000000, WAIT-state cycle limit; used only with IOREAD_TIMEOUT_EN (>=1).

Ports:
- clk  in  1  CPU clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ior  in  1  read request from Controller; held high until isIOReadOK is seen.
- ch_sel  in  N_CH  one-hot channel select, sampled when the request is accepted.
- sw_in  in  N_CH*DATA_W  raw switch bus; channel k = sw_in[(N_CH-k)*DATA_W-1 -: DATA_W].
- enter  in  1  raw enter button, asynchronous, active-high.
- ioread_data  out  DATA_W  captured channel value to memorio, registered.
- isIOReadOK  out  1  read complete, held high until ior falls.
- busy  out  1  high in WAIT (waiting for press).
- sel_err  out  1  high in ERR (ch_sel not one-hot at request).
- timeout  out  1  high in DONE when the read ended by timeout; constant 0 without IOREAD_TIMEOUT_EN.

Behaviour:
- Reset, sampled on clk: state=IDLE; ioread_data=0, isIOReadOK=0, busy=0, sel_err=0, timeout=0; sync flops=0, debounced level=0, counters=0. Reset in any state aborts the read.
- enter path: 2-flop synchroniser, then debouncer. The counter increments while the synced level differs from the debounced level and clears when they are equal. When the counter reaches DEBOUNCE_CYC, the debounced level flips and the counter clears.
- press = one-cycle pulse on the debounced 0->1 transition. A held button gives exactly one press; the next press needs a debounced release first.
- press latency: press is high DEBOUNCE_CYC+2 cycles after enter rises at the pin, provided enter stays stable.
- IDLE:
  - ior=1 and ch_sel one-hot -> WAIT; latch the channel index.
  - ior=1 and ch_sel not one-hot (0 or multiple bits) -> ERR.
  - ioread_data holds its previous value.
- WAIT: busy=1.
  - ior=0 -> IDLE (abort); ioread_data unchanged.
  - Otherwise press=1 -> DONE; on the same edge, ioread_data = latched channel slice of sw_in.
  - ior=0 and press in the same cycle: abort wins.
  - A press pulse that occurs before entry into WAIT is ignored.
- DONE: isIOReadOK=1, ioread_data held. ior=0 -> IDLE; isIOReadOK falls on that edge.
- ERR: sel_err=1, ioread_data unchanged. ior=0 -> IDLE.
- Outputs are decoded from the state register only: no combinational path from ior or ch_sel to any output.
- Read latency: isIOReadOK rises 1 cycle after press.
- Back-to-back reads: a new request is accepted no earlier than the cycle after returning to IDLE; ior must drop for at least 1 cycle between reads.

Optional Feature:
- Macro: IOREAD_TIMEOUT_EN.
- With macro:
  - A WAIT counter clears on entry to WAIT.
  - When it reaches TIMEOUT_CYC without press or abort: -> DONE with ioread_data=0 and timeout=1.
  - timeout clears when leaving DONE.
  - press wins over timeout in the same cycle.
- Without macro: no counter; WAIT waits indefinitely; timeout tied to 0.

Test Plan (DEBOUNCE_CYC=4, N_CH=2, DATA_W=8):
- sw_in=16'hA55A, ch_sel=2'b10, ior=1, clean enter pulse held 10 cycles -> busy=1 until press, then ioread_data=8'hA5 and isIOReadOK=1 one cycle after press; OK held until ior=0, then falls the next edge.
- Same request with ch_sel=2'b01 -> ioread_data=8'h5A. With ch_sel=2'b11 -> sel_err=1, data unchanged, no OK; sel_err clears after ior=0.
- enter toggling every 2 cycles for 20 cycles, then held -> exactly one press; data captured once.
- enter held high from before ior rises -> no capture; release >=4 cycles, press again -> capture.
- ior dropped in WAIT, and separately reset asserted mid-WAIT -> return to IDLE; reset also forces all outputs to 0 on the next edge; a later press produces no OK.
- With IOREAD_TIMEOUT_EN, TIMEOUT_CYC=50, no press -> after 50 WAIT cycles: isIOReadOK=1, timeout=1, ioread_data=8'h00.
